aud_i2s_recorder: RTL and testbench

//  Capture stage upstream of the SRAM write path in the lab3 recorder. Oversamples the codec's BCLK/ADCLRCK in the
//  12 MHz system domain and deserializes left-channel I2S ADC data into 16-bit samples. Emits each sample with a

---
 rtl/aud_pkg.sv | 16 +
 rtl/aud_sync_edge.sv | 27 ++
 rtl/aud_i2s_recorder.sv | 178 +++++++++++++++++
 tb/tb_aud_i2s_recorder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types and default widths for the lab3 audio recorder capture path.
package aud_pkg;

  localparam int REC_DATA_W = 16;
  localparam int REC_ADDR_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_L = 3'd1,
    ST_SKIP   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_EMIT   = 3'd4,
    ST_PAUSED = 3'd5
  } rec_state_e;

endpackage

// File: rtl/aud_sync_edge.sv
// Two-flop synchronizer for an asynchronous codec pin with a one-cycle rising-edge pulse.
module aud_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/aud_i2s_recorder.sv
// Oversampled I2S left-channel capture producing addressed samples for the SRAM writer.
// Define AUD_REC_PEAK_EN to track the absolute peak of captured samples on o_peak.
module aud_i2s_recorder
  import aud_pkg::*;
#(
  parameter int                DATA_W   = REC_DATA_W,
  parameter int                ADDR_W   = REC_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_aud_bclk,
  input  logic              i_aud_lrc,
  input  logic              i_aud_adcdat,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_full,
  output logic [2:0]        o_state,
  output logic [DATA_W-1:0] o_peak
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rec_state_e        r_state;
  rec_state_e        w_nextState;
  logic              w_bclkRise;
  logic              r_lrcMeta, r_lrcSync, r_datMeta, r_datSync;
  logic              r_lrcPrev;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] r_len;
  logic              r_full;
  logic              r_pendStart, r_pendPause, r_pendStop;
  logic              w_start, w_pause, w_stop, w_active;

  aud_sync_edge u_bclkSync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_aud_bclk),
    .o_rise  (w_bclkRise)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lrcMeta <= 1'b0;
      r_lrcSync <= 1'b0;
      r_datMeta <= 1'b0;
      r_datSync <= 1'b0;
    end else begin
      r_lrcMeta <= i_aud_lrc;
      r_lrcSync <= r_lrcMeta;
      r_datMeta <= i_aud_adcdat;
      r_datSync <= r_datMeta;
    end
  end

  // Key pulses landing on the EMIT cycle are held one cycle so they are never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pendStart <= 1'b0;
      r_pendPause <= 1'b0;
      r_pendStop  <= 1'b0;
    end else if (r_state == ST_EMIT) begin
      r_pendStart <= i_start;
      r_pendPause <= i_pause;
      r_pendStop  <= i_stop;
    end else begin
      r_pendStart <= 1'b0;
      r_pendPause <= 1'b0;
      r_pendStop  <= 1'b0;
    end
  end

  assign w_start  = i_start | r_pendStart;
  assign w_pause  = i_pause | r_pendPause;
  assign w_stop   = i_stop  | r_pendStop;
  assign w_active = (r_state == ST_WAIT_L) || (r_state == ST_SKIP) || (r_state == ST_SHIFT);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_EMIT) begin
      w_nextState = (r_address == MAX_ADDR) ? ST_IDLE : ST_WAIT_L;
    end else if (w_stop) begin
      w_nextState = ST_IDLE;
    end else if (w_pause && w_active) begin
      w_nextState = ST_PAUSED;
    end else if (w_start && !w_pause && (r_state == ST_IDLE || r_state == ST_PAUSED)) begin
      w_nextState = ST_WAIT_L;
    end else if (w_bclkRise) begin
      case (r_state)
        ST_WAIT_L: if (!r_lrcSync && r_lrcPrev) w_nextState = ST_SKIP;
        ST_SKIP:   w_nextState = ST_SHIFT;
        ST_SHIFT: begin
          if (r_lrcSync)                  w_nextState = ST_WAIT_L;
          else if (r_bitCnt == LAST_BIT)  w_nextState = ST_EMIT;
        end
        default:   w_nextState = r_state;
      endcase
    end
  end

  always_comb begin
    o_valid = (r_state == ST_EMIT);
    o_state = r_state;
  end

  // A sample only advances the bit counter while it is still heading for EMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lrcPrev <= 1'b0;
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_address <= '0;
      r_len     <= '0;
      r_full    <= 1'b0;
    end else begin
      if (w_bclkRise) r_lrcPrev <= r_lrcSync;
      if (r_state == ST_IDLE && w_nextState == ST_WAIT_L) begin
        r_address <= '0;
        r_len     <= '0;
        r_full    <= 1'b0;
      end
      if (r_state == ST_SKIP && w_nextState == ST_SHIFT) r_bitCnt <= '0;
      if (r_state == ST_SHIFT && w_bclkRise &&
          (w_nextState == ST_SHIFT || w_nextState == ST_EMIT)) begin
        r_shift <= {r_shift[DATA_W-2:0], r_datSync};
        if (r_bitCnt != LAST_BIT) r_bitCnt <= r_bitCnt + 1'b1;
      end
      if (r_state == ST_EMIT) begin
        if (r_len != {ADDR_W{1'b1}}) r_len <= r_len + 1'b1;
        if (r_address == MAX_ADDR) r_full    <= 1'b1;
        else                       r_address <= r_address + 1'b1;
      end
    end
  end

  assign o_address = r_address;
  assign o_data    = r_shift;
  assign o_len     = r_len;
  assign o_full    = r_full;

`ifdef AUD_REC_PEAK_EN
  logic [DATA_W-1:0] r_peak;
  logic [DATA_W-1:0] w_mag;

  // The most negative code has no positive twin, so it clamps to the largest positive value.
  always_comb begin
    w_mag = r_shift;
    if (r_shift[DATA_W-1]) begin
      w_mag = ~r_shift + 1'b1;
      if (w_mag[DATA_W-1]) w_mag = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                                              r_peak <= '0;
    else if (r_state == ST_IDLE && w_nextState == ST_WAIT_L) r_peak <= '0;
    else if (r_state == ST_EMIT && w_mag > r_peak)          r_peak <= w_mag;
  end

  assign o_peak = r_peak;
`else
  assign o_peak = '0;
`endif

endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Scoreboard bench for aud_i2s_recorder: a frame-level codec model drives I2S, a monitor checks every sample.
module tb_aud_i2s_recorder;

  localparam int             DW   = 16;
  localparam int             AW   = 20;
  localparam logic [AW-1:0]  MAXA = 20'd3;
  localparam int K_START = 1;
  localparam int K_PAUSE = 2;
  localparam int K_STOP  = 4;
  localparam int K_RST   = 8;
  localparam int NO_CTRL = -1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, pause, stop, bclk, lrc, dat;
  logic [AW-1:0] o_address, o_len;
  logic [DW-1:0] o_data, o_peak;
  logic          o_valid, o_full;
  logic [2:0]    o_state;

  exp_t          expQ[$];
  exp_t          monExp;
  int            compared = 0;
  int            mismatched = 0;

  // Recording model: 0 idle, 1 recording, 5 paused (matches the display code).
  int            mState;
  logic [AW-1:0] mAddr, mLen;
  logic          mFull;
  logic [DW-1:0] mPeak;

  always #5 clk = ~clk;

  aud_i2s_recorder #(.DATA_W(DW), .ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_aud_bclk(bclk), .i_aud_lrc(lrc), .i_aud_adcdat(dat),
    .o_address(o_address), .o_data(o_data), .o_valid(o_valid), .o_len(o_len),
    .o_full(o_full), .o_state(o_state), .o_peak(o_peak)
  );

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got addr=%h data=%h, expected no sample", o_address, o_data);
      end else begin
        monExp = expQ.pop_front();
        if (o_address !== monExp.addr || o_data !== monExp.data) begin
          mismatched++;
          $display("[TB] FAIL sample: got addr=%h data=%h, expected addr=%h data=%h",
                   o_address, o_data, monExp.addr, monExp.data);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_len"},   32'(o_len),     32'(mLen));
    checkOutput({tag, "_addr"},  32'(o_address), 32'(mAddr));
    checkOutput({tag, "_full"},  32'(o_full),    32'(mFull));
    checkOutput({tag, "_state"}, 32'(o_state),   32'(mState));
    checkOutput({tag, "_peak"},  32'(o_peak),    32'(mPeak));
  endtask

  task automatic applyCtrl(input int kind);
    if (kind & K_RST) begin
      mState = 0; mAddr = '0; mLen = '0; mFull = 1'b0; mPeak = '0;
    end else if (kind & K_STOP) begin
      mState = 0;
    end else if (kind & K_PAUSE) begin
      if (mState == 1) mState = 5;
    end else if (kind & K_START) begin
      if (mState == 0) begin
        mState = 1; mAddr = '0; mLen = '0; mFull = 1'b0; mPeak = '0;
      end else if (mState == 5) begin
        mState = 1;
      end
    end
  endtask

  // One 64-slot frame, 8 system clocks per bit; data and LRC change while BCLK is low.
  // The left word's MSB sits on the third rise after LRC falls: one rise locks, one is skipped.
  task automatic sendFrame(input logic [DW-1:0] left, input logic [DW-1:0] right,
                           input int leftLen, input int ctrlSlot, input int ctrlKind);
    for (int s = 0; s < 64; s++) begin
      bclk = 1'b0;
      lrc  = (s < leftLen) ? 1'b0 : 1'b1;
      if (s >= 2 && s <= 17)       dat = left[17 - s];
      else if (s >= 34 && s <= 49) dat = right[49 - s];
      else                         dat = 1'($urandom_range(0, 1));
      if (s == ctrlSlot) begin
        start = (ctrlKind & K_START) != 0;
        pause = (ctrlKind & K_PAUSE) != 0;
        stop  = (ctrlKind & K_STOP)  != 0;
        rst   = (ctrlKind & K_RST)   != 0;
      end
      @(negedge clk);
      start = 1'b0; pause = 1'b0; stop = 1'b0; rst = 1'b0;
      repeat (3) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] left, input logic [DW-1:0] right,
                               input int leftLen, input int ctrlSlot, input int ctrlKind);
    bit leftCtrl, kill, captured;
    leftCtrl = (ctrlSlot >= 0) && (ctrlSlot < 18);
    kill     = leftCtrl && ((ctrlKind & (K_STOP | K_PAUSE | K_RST)) != 0);
    captured = (mState == 1) && (leftLen == 32) && !kill;
    if (leftCtrl) applyCtrl(ctrlKind);
    if (captured) begin
      expQ.push_back('{addr: mAddr, data: left});
      if (mLen != {AW{1'b1}}) mLen = mLen + 20'd1;
`ifdef AUD_REC_PEAK_EN
      if (magnitude(left) > mPeak) mPeak = magnitude(left);
`endif
      if (mAddr == MAXA) begin
        mFull  = 1'b1;
        mState = 0;
      end else begin
        mAddr = mAddr + 20'd1;
      end
    end
    if (ctrlSlot >= 18) applyCtrl(ctrlKind);
    sendFrame(left, right, leftLen, ctrlSlot, ctrlKind);
  endtask

  task automatic startFrame();
    applyStimulus(16'($urandom), 16'($urandom), 32, 40, K_START);
  endtask

  task automatic plainFrame(input logic [DW-1:0] left);
    applyStimulus(left, 16'($urandom), 32, NO_CTRL, 0);
  endtask

  initial begin
    int r;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    bclk = 1'b0; lrc = 1'b1; dat = 1'b0;
    mState = 0; mAddr = '0; mLen = '0; mFull = 1'b0; mPeak = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkAll("reset");

    startFrame();
    applyStimulus(16'hA55A, 16'h1234, 32, NO_CTRL, 0);
    checkAll("single");

    applyStimulus(16'($urandom), 16'($urandom), 32, 40, K_STOP);
    startFrame();
    for (int i = 1; i <= 3; i++) plainFrame(16'(i));
    checkAll("three");

    applyStimulus(16'($urandom), 16'($urandom), 32, 40, K_STOP);
    startFrame();
    plainFrame(16'h1111);
    applyStimulus(16'h2222, 16'($urandom), 32, 10, K_PAUSE);
    checkAll("paused");
    startFrame();
    plainFrame(16'h3333);
    checkAll("resumed");

    applyStimulus(16'($urandom), 16'($urandom), 32, 40, K_STOP);
    startFrame();
    for (int i = 0; i < 6; i++) plainFrame(16'($urandom));
    checkAll("full");

    startFrame();
    plainFrame(16'($urandom));
    applyStimulus(16'($urandom), 16'($urandom), 32, 8, K_STOP | K_PAUSE);
    checkAll("stoppause");
    startFrame();
    checkAll("restart");
    plainFrame(16'($urandom));

    applyStimulus(16'($urandom), 16'($urandom), 10, NO_CTRL, 0);
    plainFrame(16'($urandom));
    checkAll("abort");

    applyStimulus(16'($urandom), 16'($urandom), 32, 10, K_RST);
    checkAll("midreset");

    startFrame();
    plainFrame(16'h0100);
    plainFrame(16'hF000);
    plainFrame(16'h0200);
    checkAll("peak");
    plainFrame(16'h8000);
    checkAll("peakclamp");

    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        5:       applyStimulus(16'($urandom), 16'($urandom), 32, $urandom_range(3, 16), K_PAUSE);
        6, 7:    applyStimulus(16'($urandom), 16'($urandom), 32, $urandom_range(40, 60), K_START);
        8:       applyStimulus(16'($urandom), 16'($urandom), 32, $urandom_range(40, 60), K_PAUSE);
        9:       applyStimulus(16'($urandom), 16'($urandom), 32, $urandom_range(3, 16), K_STOP);
        10:      applyStimulus(16'($urandom), 16'($urandom), $urandom_range(4, 17), NO_CTRL, 0);
        11:      applyStimulus(16'($urandom), 16'($urandom), 32, $urandom_range(3, 16), K_START);
        default: plainFrame(16'($urandom));
      endcase
      checkAll("random");
    end

    repeat (10) @(negedge clk);
    checkOutput("pending_samples", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
